vga_sync_ctrl: RTL and testbench
================================

# vga_sync_ctrl

Timing controller that sequences the pixel generator. From the 100 MHz system clock it derives a pixel-rate enable, runs the horizontal and vertical scan counters, and produces `hsync`, `vsync`, `video_on`, `pixel_x`, `pixel_y` and frame/line markers. `pixel_x`, `pixel_y` and `video_on` drive the pixel generator directly; `hsync` and `vsync` go to the VGA connector.

## Interface

Parameters:
- `DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz). Must be ≥ 1.
- `H_DISP`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_DISP`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `SYNC_POL`, 0: sync active level (0 = active-low).

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `p_tick` out 1: pixel enable, high for one `clk` cycle every `DIV` cycles.
- `pixel_x` out 10: current horizontal count, 0 to H_TOTAL−1.
- `pixel_y` out 10: current vertical count, 0 to V_TOTAL−1.
- `video_on` out 1: high when `pixel_x` < H_DISP and `pixel_y` < V_DISP.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `line_start` out 1: one-cycle pulse when `pixel_x` becomes 0.
- `frame_start` out 1: one-cycle pulse when (`pixel_x`, `pixel_y`) becomes (0, 0).

## Operation

Derived values: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).

Divider:
- `div_cnt` runs 0..DIV−1 and wraps.
- `p_tick` is registered and is high in the cycle after `div_cnt` = DIV−1.
- With DIV = 1, `p_tick` is constantly high once out of reset.

Horizontal counter:
- Advances only on clock edges where `p_tick` is high.
- Runs 0..H_TOTAL−1, then wraps to 0.

Vertical counter:
- Advances on a `p_tick` edge where the horizontal counter wraps.
- Runs 0..V_TOTAL−1, then wraps to 0.
- Both counters wrap together at (H_TOTAL−1, V_TOTAL−1) → (0, 0).

Sync decode:
- `hsync` is active for H_DISP+H_FP ≤ x ≤ H_DISP+H_FP+H_SYNC−1 (656..751).
- `vsync` is active for V_DISP+V_FP ≤ y ≤ V_DISP+V_FP+V_SYNC−1 (490..491).
- "Active" means level SYNC_POL; both are at ~SYNC_POL otherwise.

Register timing:
- `video_on`, `hsync`, `vsync`, `line_start` and `frame_start` are registered.
- They are decoded from the count value being loaded, so at every edge they are consistent with the `pixel_x`/`pixel_y` presented in the same cycle. They never lag the counters by a cycle.
- `line_start` and `frame_start` are high for exactly one `clk` cycle: the cycle after the loading edge. Both are high together at a frame wrap.

Reset (asynchronous, whenever `reset_n` = 0, including mid-line or mid-frame):
- `div_cnt` = 0, `pixel_x` = 0, `pixel_y` = 0.
- `p_tick` = 0, `video_on` = 0, `line_start` = 0, `frame_start` = 0.
- `hsync` = `vsync` = ~SYNC_POL (inactive).

After reset is released:
- The first edge reloads the decodes for (0, 0): `video_on` = 1, syncs inactive.
- No `line_start`/`frame_start` pulse is generated for the reset-time (0, 0).
- The first `p_tick` occurs DIV edges after release. Counting then proceeds normally.

Width rule: counters are 10 bits, so H_TOTAL and V_TOTAL must be ≤ 1024. No overflow case exists within that bound.

## Timing

- One pixel = DIV `clk` cycles (40 ns at defaults).
- One line = H_TOTAL·DIV cycles (3200).
- One frame = H_TOTAL·V_TOTAL·DIV cycles (1,680,000; 16.8 ms, 59.5 Hz).
- `hsync` active for H_SYNC·DIV cycles (384) per line.
- `vsync` active for V_SYNC·H_TOTAL·DIV cycles (6400) per frame.
- `video_on` is high for H_DISP of every H_TOTAL pixels on lines 0..V_DISP−1, and low for the whole of lines V_DISP..V_TOTAL−1.
- Combinational path from `pixel_x`/`pixel_y`/`video_on` through the pixel generator must close within one `clk` period.

## Test plan

- **Divider:** release reset, count `clk` cycles between consecutive `p_tick` highs → exactly 4 each; with DIV = 1, `p_tick` is high every cycle.
- **Horizontal sweep:** over one line, `video_on` is 1 at x = 639 and 0 at x = 640. `hsync` is 1 at x = 655, 0 at x = 656..751, and 1 at x = 752. After x = 799 the next value is x = 0, `pixel_y` increments, and `line_start` pulses for one `clk` cycle.
- **Vertical sweep:** `video_on` is 0 for all x on y = 480..524. `vsync` is low only on y = 490..491. After (799, 524) the next value is (0, 0), with `frame_start` and `line_start` both high for one cycle.
- **Frame period:** measure `frame_start` to `frame_start` → 1,680,000 `clk` cycles; 525 `line_start` pulses and 6400 `vsync`-low cycles per frame.
- **Reset mid-frame:** assert `reset_n` = 0 at (300, 200) asynchronously, between edges. All outputs take their reset values immediately, without waiting for an edge. After release the scan restarts from (0, 0) with the first `p_tick` after 4 edges and no spurious `frame_start`.
- **Small-parameter run:** H = 4/1/2/1, V = 3/1/1/1, DIV = 2. Compare every cycle against a scoreboard model of the counters and all decodes over 3 frames, with zero mismatches.

Source files
------------

// File: rtl/vga_sync_ctrl.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical scan counters,
// and registered sync/blanking/marker decodes aligned with the counters.
`timescale 1ns/1ps
module vga_sync_ctrl #(
    parameter int   DIV      = 4,
    parameter int   H_DISP   = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_DISP   = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_DISP);
    localparam logic [9:0]    V_VIS    = 10'(V_DISP);
    localparam logic [9:0]    HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          vid_q, hs_q, vs_q, ls_q, fs_q;

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d = (div_q == DIV_LAST);
        x_d    = x_q;
        y_d    = y_q;
        if (tick_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Decodes look at the value being loaded so they line up with the counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            vid_q  <= 1'b0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            x_q    <= x_d;
            y_q    <= y_d;
            vid_q  <= (x_d < H_VIS) && (y_d < V_VIS);
            hs_q   <= ((x_d >= HS_START) && (x_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
            vs_q   <= ((y_d >= VS_START) && (y_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
            ls_q   <= tick_q && (x_d == '0);
            fs_q   <= tick_q && (x_d == '0) && (y_d == '0);
        end
    end

    assign p_tick      = tick_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = vid_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench for vga_sync_ctrl: a full-width line instance, plus two tiny
// instances compared cycle by cycle against a closed-form timing model.
`timescale 1ns/1ps
module tb_vga_sync_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       a_tick, a_vid, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_vid, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_tick, c_vid, c_hs, c_vs, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit mdl_en = 1'b0;
  bit lost = 1'b0;

  // Full horizontal timing, short frame (8 lines, vsync on y = 5..6).
  vga_sync_ctrl #(.DIV(4), .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_a (
    .clk(clk), .reset_n(reset_n), .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_vid), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_sync_ctrl #(.DIV(2), .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_b (
    .clk(clk), .reset_n(reset_n), .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_vid), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_sync_ctrl #(.DIV(1), .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_c (
    .clk(clk), .reset_n(reset_n), .p_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
    .video_on(c_vid), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected state after t edges since reset release, from elapsed time alone.
  function automatic void model(input int tt, input int div,
                                input int hd, input int hf, input int hs, input int hb,
                                input int vd, input int vf, input int vs, input int vb,
                                output int ex, output int ey, output bit etick, output bit evid,
                                output bit ehs, output bit evs, output bit els, output bit efs);
    int ht, vt, n;
    bit adv;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    if (tt == 0) begin
      ex = 0; ey = 0; etick = 0; evid = 0; ehs = 1; evs = 1; els = 0; efs = 0;
    end else begin
      n     = (tt - 1) / div;
      ex    = n % ht;
      ey    = (n / ht) % vt;
      etick = ((tt % div) == 0);
      adv   = (tt >= 2) && (((tt - 1) % div) == 0);
      evid  = (ex < hd) && (ey < vd);
      ehs   = !((ex >= hd + hf) && (ex < hd + hf + hs));
      evs   = !((ey >= vd + vf) && (ey < vd + vf + vs));
      els   = adv && (ex == 0);
      efs   = els && (ey == 0);
    end
  endfunction

  task automatic chk_model(input string p, input int div, input logic [9:0] ox, input logic [9:0] oy,
                           input logic otick, input logic ovid, input logic ohs, input logic ovs,
                           input logic ols, input logic ofs);
    int ex, ey;
    bit etick, evid, ehs, evs, els, efs;
    model(t, div, 4, 1, 2, 1, 3, 1, 1, 1, ex, ey, etick, evid, ehs, evs, els, efs);
    chk($sformatf("%s_x@%0d", p, t), 32'(ox), ex);
    chk($sformatf("%s_y@%0d", p, t), 32'(oy), ey);
    chk($sformatf("%s_tick@%0d", p, t), 32'(otick), 32'(etick));
    chk($sformatf("%s_vid@%0d", p, t), 32'(ovid), 32'(evid));
    chk($sformatf("%s_hs@%0d", p, t), 32'(ohs), 32'(ehs));
    chk($sformatf("%s_vs@%0d", p, t), 32'(ovs), 32'(evs));
    chk($sformatf("%s_ls@%0d", p, t), 32'(ols), 32'(els));
    chk($sformatf("%s_fs@%0d", p, t), 32'(ofs), 32'(efs));
  endtask

  // One clk cycle; sample on the falling edge. Small instances are scored for ~3 frames.
  task automatic step();
    @(negedge clk);
    t++;
    if (mdl_en && t <= 300) begin
      chk_model("b", 2, b_x, b_y, b_tick, b_vid, b_hs, b_vs, b_ls, b_fs);
      chk_model("c", 1, c_x, c_y, c_tick, c_vid, c_hs, c_vs, c_ls, c_fs);
    end
  endtask

  task automatic goto(input string tag, input int x, input int y);
    int n = 0;
    int budget = lost ? 1 : 27000;
    while (!((32'(a_x) == x) && (32'(a_y) == y)) && n < budget) begin
      step();
      n++;
    end
    if (!((32'(a_x) == x) && (32'(a_y) == y))) lost = 1'b1;
    chk({tag, "_reach"}, 32'((32'(a_x) == x) && (32'(a_y) == y)), 32'd1);
  endtask

  task automatic chk_a_reset(input string p);
    chk({p, "_x"}, 32'(a_x), 0);
    chk({p, "_y"}, 32'(a_y), 0);
    chk({p, "_tick"}, 32'(a_tick), 0);
    chk({p, "_vid"}, 32'(a_vid), 0);
    chk({p, "_hs"}, 32'(a_hs), 1);
    chk({p, "_vs"}, 32'(a_vs), 1);
    chk({p, "_ls"}, 32'(a_ls), 0);
    chk({p, "_fs"}, 32'(a_fs), 0);
  endtask

  initial begin
    int n, cnt_hs, cnt_vid, cnt_ls, cnt_vs;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_a_reset("rst");

    // Release between edges; edge 1 loads decodes for (0,0)
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    t = 0;
    mdl_en = 1'b1;
    step();
    chk("first_vid", 32'(a_vid), 1);
    chk("first_hs", 32'(a_hs), 1);
    chk("first_vs", 32'(a_vs), 1);
    chk("first_ls", 32'(a_ls), 0);
    chk("first_fs", 32'(a_fs), 0);
    chk("first_x", 32'(a_x), 0);
    chk("div_t1", 32'(a_tick), 0);
    for (int i = 2; i <= 12; i++) begin
      step();
      chk($sformatf("div_t%0d", i), 32'(a_tick), 32'((i % 4) == 0));
      chk($sformatf("nofs_t%0d", i), 32'(a_fs), 0);
    end
    chk("x_after_12", 32'(a_x), 2);

    // Horizontal sweep on line 0
    goto("h639", 639, 0);  chk("vid639", 32'(a_vid), 1);
    goto("h640", 640, 0);  chk("vid640", 32'(a_vid), 0);
    goto("h655", 655, 0);  chk("hs655", 32'(a_hs), 1);
    goto("h656", 656, 0);  chk("hs656", 32'(a_hs), 0);
    goto("h751", 751, 0);  chk("hs751", 32'(a_hs), 0);
    goto("h752", 752, 0);  chk("hs752", 32'(a_hs), 1);
    goto("h799", 799, 0);  chk("vid799", 32'(a_vid), 0);
    goto("l1", 0, 1);
    chk("l1_ls", 32'(a_ls), 1);
    chk("l1_fs", 32'(a_fs), 0);
    chk("l1_vid", 32'(a_vid), 1);

    // Measure line 1: period, hsync-low and video_on-high cycles
    n = 0; cnt_hs = 0; cnt_vid = 0; cnt_ls = 0;
    do begin
      if (a_hs == 1'b0) cnt_hs++;
      if (a_vid == 1'b1) cnt_vid++;
      if (a_ls == 1'b1) cnt_ls++;
      step();
      n++;
    end while (!((a_x == 10'd0) && (a_y == 10'd2)) && n < 4000);
    chk("line_cycles", n, 3200);
    chk("line_hs_low", cnt_hs, 384);
    chk("line_vid_hi", cnt_vid, 2560);
    chk("line_ls_cnt", cnt_ls, 1);

    // Vertical: blanking lines and vsync window
    goto("v4", 0, 4);       chk("vid_y4", 32'(a_vid), 0);
    goto("v4x639", 639, 4); chk("vid_y4x639", 32'(a_vid), 0);
    goto("v4x799", 799, 4); chk("vs_y4", 32'(a_vs), 1);
    goto("v5", 0, 5);       chk("vs_y5", 32'(a_vs), 0);
    goto("v6x799", 799, 6); chk("vs_y6", 32'(a_vs), 0);
    goto("v7", 0, 7);       chk("vs_y7", 32'(a_vs), 1);
    goto("v7x799", 799, 7); chk("vid_y7", 32'(a_vid), 0);

    // Frame wrap (799,7) -> (0,0)
    goto("f0", 0, 0);
    chk("wrap_fs", 32'(a_fs), 1);
    chk("wrap_ls", 32'(a_ls), 1);
    chk("wrap_vid", 32'(a_vid), 1);

    // Frame period and per-frame counts
    n = 0; cnt_ls = 0; cnt_vs = 0;
    do begin
      step();
      n++;
      if (a_ls == 1'b1) cnt_ls++;
      if (a_vs == 1'b0) cnt_vs++;
    end while (a_fs != 1'b1 && n < 27000);
    chk("frame_cycles", n, 25600);
    chk("frame_ls_cnt", cnt_ls, 8);
    chk("frame_vs_low", cnt_vs, 6400);
    step();
    chk("fs_one_cycle", 32'(a_fs), 0);
    chk("ls_one_cycle", 32'(a_ls), 0);

    // Asynchronous reset mid-frame, between edges
    goto("mid", 300, 3);
    mdl_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_a_reset("async");
    chk("async_b_x", 32'(b_x), 0);
    chk("async_c_tick", 32'(c_tick), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    t = 0;
    mdl_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("rel_tick%0d", i), 32'(a_tick), 32'((i % 4) == 0));
      chk($sformatf("rel_fs%0d", i), 32'(a_fs), 0);
      chk($sformatf("rel_y%0d", i), 32'(a_y), 0);
      if (i == 1) chk("rel_vid", 32'(a_vid), 1);
      if (i == 4) chk("rel_x4", 32'(a_x), 0);
      if (i == 5) chk("rel_x5", 32'(a_x), 1);
    end
    while (t < 300) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
